// File: rtl/mm_sched_if.sv
// mm_sched_if: command, array-control and result-drain signals of the tile scheduler
interface mm_sched_if #(parameter int N = 8, parameter int KW = 8);
  logic          start;
  logic [KW-1:0] k_len;
  logic [3:0]    conf;
  logic          stall;
  logic          busy;
  logic          done;
  logic          err;
  logic          rd_en;
  logic [KW-1:0] rd_addr;
  logic          arr_enable;
  logic [3:0]    arr_conf;
  logic [N-1:0]  clear_vec;
  logic          out_valid;
  logic [2:0]    out_row;
  modport master (
    output start, k_len, conf, stall,
    input  busy, done, err, rd_en, rd_addr, arr_enable, arr_conf, clear_vec, out_valid, out_row
  );
  modport slave (
    input  start, k_len, conf, stall,
    output busy, done, err, rd_en, rd_addr, arr_enable, arr_conf, clear_vec, out_valid, out_row
  );
endinterface

// File: rtl/mm_sched.sv
// mm_sched: tile scheduler for the NxN systolic array; sequences operand reads, skewed row clears and result drain.
module mm_sched #(parameter int N = 8, parameter int KW = 8) (
  input logic       clk,
  input logic       reset,
  mm_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t        r_state, w_state;
  logic [KW:0]   r_c, w_c, r_k, w_k;
  logic          w_acc, w_hold, w_rd;
  logic [N-1:0]  w_clr;
  always_comb begin
    w_acc   = r_state == IDLE && bus.start && bus.k_len != '0;
    w_hold  = (r_state == RUN || r_state == DRAIN) && bus.stall;
    w_k     = w_acc ? {1'b0, bus.k_len} : r_k;
    w_state = w_hold ? r_state
            : r_state == IDLE  ? (w_acc ? RUN : IDLE)
            : r_state == RUN   ? (r_c == r_k + (KW+1)'(N-1) ? DRAIN : RUN)
            : r_state == DRAIN ? (r_c == (KW+1)'(N-1) ? DONE : DRAIN)
            : IDLE;
    w_c     = w_hold ? r_c
            : (w_state == r_state && r_state != IDLE) ? r_c + (KW+1)'(1) : '0;
    w_rd    = w_state == RUN && w_c < w_k;
    w_clr   = '0;
    // row i starts accumulating at step i and commits its sum at step K+i
    for (int i = 0; i < N; i++)
      w_clr[i] = w_state == RUN && (w_c == (KW+1)'(i) || w_c == w_k + (KW+1)'(i));
  end
  // outputs are registered from the next-state view, so they line up with the state they describe
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_c            <= '0;
      r_k            <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.err        <= 1'b0;
      bus.rd_en      <= 1'b0;
      bus.rd_addr    <= '0;
      bus.arr_enable <= 1'b0;
      bus.arr_conf   <= '0;
      bus.clear_vec  <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_row    <= '0;
    end else begin
      r_state        <= w_state;
      r_c            <= w_c;
      r_k            <= w_k;
      if (w_acc) bus.arr_conf <= bus.conf;
      bus.busy       <= w_state == RUN || w_state == DRAIN;
      bus.done       <= w_state == DONE;
      bus.err        <= r_state == IDLE && bus.start && bus.k_len == '0;
      bus.arr_enable <= !w_hold && (w_state == RUN || w_state == DRAIN);
      bus.rd_en      <= !w_hold && w_rd;
      bus.clear_vec  <= w_hold ? '0 : w_clr;
      bus.out_valid  <= !w_hold && w_state == DRAIN;
      if (!w_hold) begin
        bus.rd_addr <= w_rd ? w_c[KW-1:0] : '0;
        bus.out_row <= w_state == DRAIN ? w_c[2:0] : '0;
      end
    end
  end
endmodule

// File: tb/tb_mm_sched.sv
// tb_mm_sched: randomized scoreboard bench; expected tile events come from a step-level model of the schedule.
module tb_mm_sched;
  localparam int N = 8;
  localparam int KW = 8;
  typedef struct packed {
    logic       rd;
    logic [7:0] addr;
    logic [7:0] clr;
    logic       ov;
    logic [2:0] row;
    logic       dn;
    logic       er;
    logic [3:0] cf;
  } ev_t;
  logic clk = 0;
  logic rst_n = 0;
  logic mon_en = 0;
  logic tb_busy = 0;
  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;
  logic [3:0] m_conf = 0;
  ev_t exp_q[$];
  int done_q[$];
  ev_t got, want;
  logic [7:0] prev_addr = 0;
  logic [2:0] prev_row = 0;
  mm_sched_if #(.N(N), .KW(KW)) b();
  mm_sched #(.N(N), .KW(KW)) dut (.clk(clk), .reset(rst_n), .bus(b));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] g, input logic [31:0] w);
    n_chk++;
    if (g !== w) begin
      n_err++;
      $display("FAIL %s: got %h want %h at cycle %0d", nm, g, w, cyc);
    end
  endtask
  // expected event per presented step: K+N run steps, N drain rows, then done
  task automatic push_tile(input int k, input logic [3:0] cf, input int upto);
    ev_t e;
    for (int s = 0; s < k + 2*N && s < upto; s++) begin
      e = '0;
      e.cf = cf;
      if (s < k + N) begin
        e.rd = s < k;
        e.addr = s < k ? 8'(s) : 8'd0;
        for (int i = 0; i < N; i++) e.clr[i] = (s == i) || (s == k + i);
      end else begin
        e.ov = 1;
        e.row = 3'(s - k - N);
      end
      exp_q.push_back(e);
    end
    if (upto >= k + 2*N) begin
      e = '0;
      e.dn = 1;
      e.cf = cf;
      exp_q.push_back(e);
    end
  endtask
  task automatic check_zero(input string nm);
    chk(nm, 32'({b.busy, b.done, b.err, b.rd_en, b.rd_addr, b.arr_enable, b.arr_conf,
                 b.clear_vec, b.out_valid, b.out_row}), 32'd0);
  endtask
  // mode 0 random stall/start noise, 1 clean, 2 stall 3 cycles at step 4, 3 re-start with k_len=3
  task automatic run_tile(input int k, input logic [3:0] cf, input int mode, input int exp_lat, input int rst_at);
    int t1, rem, extra, pres;
    logic s;
    b.start = 1;
    b.k_len = 8'(k);
    b.conf = cf;
    b.stall = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    t1 = cyc;
    tb_busy = 1;
    m_conf = cf;
    rem = k + 2*N;
    extra = 0;
    push_tile(k, cf, rst_at < 0 ? k + 2*N : rst_at + 1);
    while (rem > 0) begin
      pres = k + 2*N - rem;
      if (rst_at >= 0 && pres == rst_at) begin
        rst_n = 0;
        b.start = 0;
        b.stall = 0;
        @(posedge clk); #1;
        tb_busy = 0;
        m_conf = 0;
        check_zero("reset_mid_tile");
        rst_n = 1;
        return;
      end
      s = mode == 0 ? ($urandom_range(0, 3) == 0) : mode == 2 ? (pres == 4 && extra < 3) : 1'b0;
      b.stall = s;
      b.start = (mode == 0 || mode == 3) ? ($urandom_range(0, 2) == 0) : 1'b0;
      b.k_len = mode == 3 ? 8'd3 : 8'($urandom_range(0, 3));
      b.conf = 4'($urandom);
      @(posedge clk); #1;
      if (s) extra++;
      else rem--;
    end
    tb_busy = 0;
    done_q.push_back(exp_lat >= 0 ? t1 - 1 + exp_lat : t1 + k + 2*N + extra);
    b.start = mode == 0 ? 1'($urandom_range(0, 1)) : 1'b0;
    b.stall = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    b.start = 0;
  endtask
  task automatic do_err();
    ev_t e;
    b.start = 1;
    b.k_len = 0;
    b.conf = 4'($urandom);
    @(posedge clk); #1;
    e = '0;
    e.er = 1;
    e.cf = m_conf;
    exp_q.push_back(e);
    b.start = 0;
    @(posedge clk); #1;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      b.start = 0;
      b.stall = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
  endtask
  always @(negedge clk) if (mon_en) begin
    int dc;
    got = {b.rd_en, b.rd_addr, b.clear_vec, b.out_valid, b.out_row, b.done, b.err, b.arr_conf};
    chk("busy", 32'(b.busy), 32'(tb_busy));
    chk("enable", 32'(b.arr_enable), 32'(b.rd_en | (|b.clear_vec) | b.out_valid));
    if (b.busy && !b.arr_enable) chk("stall_hold", 32'({b.rd_addr, b.out_row}), 32'({prev_addr, prev_row}));
    if (b.rd_en || b.clear_vec != 0 || b.out_valid || b.done || b.err) begin
      if (exp_q.size() == 0) chk("unexpected_event", 32'(got), 32'd0);
      else begin
        want = exp_q.pop_front();
        chk("event", 32'(got), 32'(want));
        if (b.done) begin
          if (done_q.size() == 0) chk("unexpected_done", 32'(cyc), 32'd0);
          else begin
            dc = done_q.pop_front();
            chk("done_cycle", 32'(cyc), 32'(dc));
          end
        end
      end
    end
    prev_addr = b.rd_addr;
    prev_row = b.out_row;
  end
  initial begin
    b.start = 0;
    b.k_len = 0;
    b.conf = 0;
    b.stall = 0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_state");
    rst_n = 1;
    mon_en = 1;
    idle(2);
    run_tile(1, 4'h5, 1, 18, -1);
    idle(1);
    run_tile(8, 4'hA, 1, 25, -1);
    run_tile(8, 4'h3, 2, 28, -1);
    do_err();
    run_tile(8, 4'h6, 3, 25, -1);
    run_tile(8, 4'h9, 1, -1, 8 + N + 2);
    run_tile(2, 4'hC, 1, 19, -1);
    run_tile(255, 4'h7, 0, -1, -1);
    repeat (40) begin
      if ($urandom_range(0, 4) == 0) do_err();
      else run_tile($urandom_range(1, 24), 4'($urandom), 0, -1, -1);
      idle($urandom_range(0, 3));
    end
    idle(3);
    chk("leftover_events", 32'(exp_q.size()), 32'd0);
    chk("leftover_done", 32'(done_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mm_sched.md
# mm_sched

Tile scheduler for the 8x8 systolic multiply array. Accepts a start command with an accumulation length K and a 4-bit array configuration, then runs one tile: operand buffer reads, the array enable, the diagonally skewed per-row clear vector, and the result drain. It sits between the training-loop sequencer, which issues commands, and the array plus its operand buffers and result collector. Downstream backpressure freezes the whole tile in place.

## Interface
- N, 8, array dimension (rows, and lanes of clear_vec)
- KW, 8, width of k_len and rd_addr
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  command strobe, sampled in IDLE only
- k_len  in  KW  accumulation steps K for the tile
- conf  in  4  array configuration, latched at accepted start
- stall  in  1  result-consumer backpressure
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse, tile complete
- err  out  1  one-cycle pulse, start rejected because k_len==0
- rd_en  out  1  operand buffer read strobe
- rd_addr  out  KW  operand buffer step index
- arr_enable  out  1  array global enable
- arr_conf  out  4  latched conf, stable for the whole tile
- clear_vec  out  N  per-row clear/commit strobes into the array
- out_valid  out  1  result row valid for the collector
- out_row  out  3  index of the result row being presented

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- Counter c is KW+1 bits wide so that K+N-1 does not overflow at K=255.
- IDLE, start=1, k_len!=0: latch K and conf, clear c, go to RUN.
- IDLE, start=1, k_len==0: pulse err for one cycle, stay in IDLE, leave arr_conf unchanged.
- start is ignored in every state except IDLE. No error is raised for it.
- RUN lasts K+N unstalled cycles, with c running 0..K+N-1.
  - arr_enable=1 throughout RUN.
  - rd_en=1 and rd_addr=c while c<K; otherwise rd_en=0 and rd_addr=0.
  - clear_vec[i]=1 when c==i (start of row i's accumulation) or c==K+i (commit of row i's sum). The two conditions are ORed.
  - Exit to DRAIN with c cleared after c==K+N-1.
- DRAIN lasts N unstalled cycles, with d running 0..N-1.
  - arr_enable=1, out_valid=1, out_row=d.
  - Exit to DONE after d==N-1.
- DONE: done=1 for exactly one cycle, busy=0, then return to IDLE.
- stall=1 in RUN or DRAIN:
  - c and d hold, and the state holds.
  - arr_enable, rd_en, clear_vec and out_valid are forced to 0; rd_addr and out_row hold.
  - Stalled cycles do not count toward a phase's length.
- stall has no effect in IDLE or DONE.
- Reset (reset==0 at a clock edge): state goes to IDLE; every output, c, d and the latched K are 0 after that edge. This applies mid-tile with no completion pulse. The array and buffers are reset by their own reset.

## Timing
- All outputs are registered. They change only on the rising edge of clk.
- Accepted start sampled at edge E0:
  - busy=1 and the first RUN cycle begin after E0.
  - With no stalls, done is high in cycle E0+K+2N+1, counting from E0 as cycle 0.
  - Total unstalled latency is K+2N+1 cycles; each stalled cycle adds exactly 1.
- done is low while busy is high; busy falls in the same cycle that done rises.
- The earliest next start is sampled in the cycle after done.
- err is asserted in the cycle after the rejected start.

## Test plan
- K=1 with N=8, no stall:
  - rd_en high for 1 cycle at rd_addr 0.
  - clear_vec is 0x01, 0x03, 0x06, 0x0C, 0x18, 0x30, 0x60, 0xC0, 0x80 over 9 RUN cycles.
  - 8 out_valid cycles follow with out_row 0..7.
  - done arrives 18 cycles after start; the expected sequence is checked against a reference model.
- K=8, start at cycle 0:
  - rd_addr 0..7 in cycles 1..8.
  - clear_vec[3] high in cycles 4 and 12.
  - out_valid in cycles 17..24, done in cycle 25.
  - arr_conf equals conf from start throughout.
- K=8 with stall=1 for 3 cycles while rd_addr==4:
  - rd_en=0 and arr_enable=0 during the stall, with rd_addr held at 4.
  - The sequence resumes unchanged; done arrives at cycle 28.
- start with k_len=0:
  - err pulses at cycle 1; busy stays 0; no rd_en or arr_enable activity.
- start re-asserted with k_len=3 while busy with K=8:
  - The second start is ignored; done arrives at cycle 25.
  - rd_addr never exceeds 7.
- reset=0 asserted in the third DRAIN cycle:
  - All outputs are 0 on the next cycle and the state is IDLE; no done pulse.
  - A new start with K=2 then completes in K+2N+1=19 cycles.
